// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; MUL is an iterative shift-add over WIDTH steps.
// Latency: non-MUL result one edge after accept, MUL WIDTH+1 edges; result held in HOLD until out_ready.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             c;
    logic             v;
  } res_t;

  state_t             state, state_nxt;
  logic               accept;
  logic               is_mul;
  logic               mul_done;
  res_t               alu_res;
  res_t               mul_res;
  res_t               res_q;
  logic               z_q, n_q;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign is_mul   = (s == OP_MUL);
  assign mul_done = (cnt == CW'(WIDTH));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      EXEC: if (mul_done) state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A new op may replace the drained result in the same cycle.
    if (in_valid && in_ready) state_nxt = is_mul ? EXEC : HOLD;
  end

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    diff    = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    case (s)
      OP_PASS: alu_res.y = a;
      OP_ADD: begin
        alu_res.y = sum[WIDTH-1:0];
        alu_res.c = sum[WIDTH];
        alu_res.v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res.y = diff[WIDTH-1:0];
        alu_res.c = diff[WIDTH];
        alu_res.v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res.y = a & b;
      OP_OR:   alu_res.y = a | b;
      OP_XOR:  alu_res.y = a ^ b;
      OP_NOT:  alu_res.y = ~a;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    mul_res   = '0;
    mul_res.y = acc[WIDTH-1:0];
    mul_res.c = |acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        res_q <= alu_res;
        z_q   <= (alu_res.y == '0);
        n_q   <= alu_res.y[WIDTH-1];
      end
    end else if (state == EXEC) begin
      if (!mul_done) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end else begin
        res_q <= mul_res;
        z_q   <= (mul_res.y == '0);
        n_q   <= mul_res.y[WIDTH-1];
      end
    end
  end

  assign y = res_q.y;
  assign c = res_q.c;
  assign v = res_q.v;
  assign z = z_q;
  assign n = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=4) with an arithmetic reference model and scoreboard.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, cin, out_valid, out_ready;
  logic [2:0] s;
  logic [3:0] a, b, y;
  logic       c, v, z, n;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];

  alu_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .c(c), .v(v), .z(z), .n(n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Result packed as {y[3:0], c, v, z, n}, computed with plain integer arithmetic.
  function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] aa,
                                       input logic [3:0] bb, input logic ci);
    int ia, ib, ic, sa, sb, r, sr;
    logic cc, vv;
    logic [3:0] yy;
    ia = int'(aa); ib = int'(bb); ic = int'(ci);
    sa = (ia >= 8) ? ia - 16 : ia;
    sb = (ib >= 8) ? ib - 16 : ib;
    cc = 1'b0; vv = 1'b0; r = 0;
    case (op)
      3'd0: r = ia;
      3'd1: begin r = ia + ib + ic; cc = (r > 15); sr = sa + sb + ic; vv = (sr > 7) || (sr < -8); end
      3'd2: begin r = ia - ib + 16; cc = (ia < ib); sr = sa - sb; vv = (sr > 7) || (sr < -8); end
      3'd3: r = ia & ib;
      3'd4: r = ia | ib;
      3'd5: r = ia ^ ib;
      3'd6: r = 15 - ia;
      default: begin r = ia * ib; cc = (r > 15); end
    endcase
    yy = r[3:0];
    return {yy, cc, vv, (yy == 4'd0), yy[3]};
  endfunction

  // Scoreboard: every cycle with out_valid is checked against the oldest accepted op.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("sb_unexpected_out", 32'(out_valid), 32'd0);
        else begin
          chk("sb_result", 32'({y, c, v, z, n}), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(s, a, b, cin));
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic issue(input logic [2:0] op, input logic [3:0] aa, input logic [3:0] bb,
                       input logic ci);
    int k;
    s = op; a = aa; b = bb; cin = ci; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 40) begin @(negedge clk); k++; end
    if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [7:0] r);
    int k;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    if (!out_valid) chk("out_timeout", 32'(out_valid), 32'd1);
    r = {y, c, v, z, n};
    @(posedge clk); #1;
  endtask

  logic [3:0] ye [8];
  logic [7:0] r;

  initial begin
    ye = '{4'h3, 4'hE, 4'h9, 4'h2, 4'hB, 4'h9, 4'hC, 4'hE};
    rst = 1'b1; in_valid = 1'b0; s = '0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_flags_cvzn", 32'({c, v, z, n}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: opcode sweep
    for (int i = 0; i < 8; i++) begin
      issue(3'(i), 4'h3, 4'hA, 1'b1);
      wait_out(r);
      chk($sformatf("t1_y_op%0d", i), 32'(r[7:4]), 32'(ye[i]));
      if (i == 1) chk("t1_add_c_v_n", 32'({r[3], r[2], r[0]}), 32'b001);
      if (i == 2) chk("t1_sub_c_v", 32'({r[3], r[2]}), 32'b11);
      if (i == 7) chk("t1_mul_c", 32'(r[3]), 32'd1);
    end

    // 2: MUL latency and in_ready blocking
    issue(3'd7, 4'h3, 4'hA, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t2_in_ready_%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("t2_out_valid_%0d", i), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t2_out_valid_k5", 32'(out_valid), 32'd1);
    chk("t2_y", 32'(y), 32'hE);
    @(posedge clk); #1;

    // 3: backpressure in HOLD, then same-cycle accept on release
    out_ready = 1'b0;
    issue(3'd3, 4'h3, 4'hA, 1'b1);
    s = 3'd4; a = 4'h3; b = 4'hA; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3_hold_%0d", i), 32'({out_valid, in_ready, y}), 32'({1'b1, 1'b0, 4'h2}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_next_y", 32'({out_valid, y}), 32'({1'b1, 4'hB}));
    @(posedge clk); #1;

    // 4: zero result and signed overflow corners
    issue(3'd2, 4'h5, 4'h5, 1'b1);
    wait_out(r);
    chk("t4_sub_zero", 32'(r), 32'({4'h0, 1'b0, 1'b0, 1'b1, 1'b0}));
    issue(3'd1, 4'h7, 4'h0, 1'b1);
    wait_out(r);
    chk("t4_add_ovf", 32'(r), 32'({4'h8, 1'b0, 1'b1, 1'b0, 1'b1}));

    // 5: reset in the middle of a multiply
    issue(3'd7, 4'h3, 4'hA, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_state", 32'({out_valid, in_ready, y, z}), 32'({1'b0, 1'b1, 4'h0, 1'b0}));
    @(posedge clk); #1;
    issue(3'd7, 4'h5, 4'h3, 1'b0);
    wait_out(r);
    chk("t5_mul_after_rst", 32'(r), 32'({4'hF, 1'b0, 1'b0, 1'b0, 1'b1}));

    // 6: back-to-back ops, one result per cycle
    s = 3'd1; a = 4'h1; b = 4'h2; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("t6_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    s = 3'd3; a = 4'hF; b = 4'h6;
    @(negedge clk);
    chk("t6_r0", 32'({out_valid, in_ready, y}), 32'({1'b1, 1'b1, 4'h3}));
    @(posedge clk); #1;
    s = 3'd4; a = 4'h8; b = 4'h1;
    @(negedge clk);
    chk("t6_r1", 32'({out_valid, in_ready, y}), 32'({1'b1, 1'b1, 4'h6}));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_r2", 32'({out_valid, y}), 32'({1'b1, 4'h9}));
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("final_idle", 32'({out_valid, in_ready}), 32'b01);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
